// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit with stall/bubble/flush/freeze, forwarding, watchdog and perf counters.
// Forwarding is enabled with `define HAZARD_FWD_EN; without it, any RAW dependency on a writing stage stalls.
module hazard_ctrl #(
  parameter int ADDR_LEN = 5,
  parameter int TIMEOUT  = 64,
  parameter int CNT_W    = 16
) (
  input  logic                i_CLK,
  input  logic                i_RST,
  input  logic [ADDR_LEN-1:0] rs_addr_ID,
  input  logic [ADDR_LEN-1:0] rt_addr_ID,
  input  logic                rt_used_ID,
  input  logic [ADDR_LEN-1:0] rs_addr_EX,
  input  logic [ADDR_LEN-1:0] rt_addr_EX,
  input  logic [ADDR_LEN-1:0] wb_addr_EX,
  input  logic [ADDR_LEN-1:0] wb_addr_MEM,
  input  logic [ADDR_LEN-1:0] wb_addr_WB,
  input  logic                reg_write_EX,
  input  logic                reg_write_MEM,
  input  logic                reg_write_WB,
  input  logic                mem_to_reg_EX,
  input  logic                mem_to_reg_MEM,
  input  logic                branch_ID,
  input  logic                jump_reg,
  input  logic                jump_addr,
  input  logic                branch_taken,
  input  logic                mem_busy,
  output logic                stall_pc,
  output logic                stall_if_id,
  output logic                bubble_ex,
  output logic                freeze,
  output logic                flush_if_id,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt,
  output logic                err_timeout
);
  localparam int WW = $clog2(TIMEOUT) + 1;
  logic [WW-1:0] wait_cnt;
  logic src_ex, src_mem, src_wb, lu, br, hz;
  function automatic logic hit(input logic [ADDR_LEN-1:0] a, input logic [ADDR_LEN-1:0] w, input logic we);
    return we && (w != '0) && (a == w);
  endfunction
  function automatic logic id_hit(input logic [ADDR_LEN-1:0] w, input logic we);
    return hit(rs_addr_ID, w, we) || (rt_used_ID && hit(rt_addr_ID, w, we));
  endfunction
`ifdef HAZARD_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic [ADDR_LEN-1:0] a);
    return hit(a, wb_addr_MEM, reg_write_MEM && !mem_to_reg_MEM) ? 2'b01 :
           hit(a, wb_addr_WB, reg_write_WB) ? 2'b10 : 2'b00;
  endfunction
`else
  logic unused_fwd;
  assign unused_fwd = ^{rs_addr_EX, rt_addr_EX};
`endif
  always_comb begin
    src_ex  = id_hit(wb_addr_EX, reg_write_EX);
    src_mem = id_hit(wb_addr_MEM, reg_write_MEM);
    src_wb  = id_hit(wb_addr_WB, reg_write_WB);
    lu      = mem_to_reg_EX && src_ex;
    br      = branch_ID && (src_ex || (mem_to_reg_MEM && src_mem));
`ifdef HAZARD_FWD_EN
    hz      = lu || br;
    fwd_a   = i_RST ? 2'b00 : fwd_sel(rs_addr_EX);
    fwd_b   = i_RST ? 2'b00 : fwd_sel(rt_addr_EX);
`else
    hz      = lu || br || src_ex || src_mem || src_wb;
    fwd_a   = 2'b00;
    fwd_b   = 2'b00;
`endif
    freeze      = !i_RST && mem_busy;
    stall_pc    = !i_RST && (mem_busy || hz);
    stall_if_id = stall_pc;
    bubble_ex   = !i_RST && !mem_busy && hz;
    flush_if_id = !i_RST && !mem_busy && !hz && (jump_reg || jump_addr || branch_taken);
  end
  // wait_cnt parks at TIMEOUT-1 so a long wait cannot wrap it
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      wait_cnt    <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      err_timeout <= 1'b0;
    end else begin
      wait_cnt <= !mem_busy ? '0 : (wait_cnt == WW'(TIMEOUT - 1)) ? wait_cnt : wait_cnt + WW'(1);
      if (mem_busy && wait_cnt == WW'(TIMEOUT - 1)) err_timeout <= 1'b1;
      if (bubble_ex && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_if_id && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl (TIMEOUT=4, CNT_W=2); expectations follow HAZARD_FWD_EN.
module tb_hazard_ctrl;
  logic       i_CLK = 0, i_RST;
  logic [4:0] rs_addr_ID, rt_addr_ID, rs_addr_EX, rt_addr_EX, wb_addr_EX, wb_addr_MEM, wb_addr_WB;
  logic       rt_used_ID, reg_write_EX, reg_write_MEM, reg_write_WB, mem_to_reg_EX, mem_to_reg_MEM;
  logic       branch_ID, jump_reg, jump_addr, branch_taken, mem_busy;
  logic       stall_pc, stall_if_id, bubble_ex, freeze, flush_if_id, err_timeout;
  logic [1:0] fwd_a, fwd_b, stall_cnt, flush_cnt;
  int errors = 0, checks = 0;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  hazard_ctrl #(.ADDR_LEN(5), .TIMEOUT(4), .CNT_W(2)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .rs_addr_ID(rs_addr_ID), .rt_addr_ID(rt_addr_ID), .rt_used_ID(rt_used_ID),
    .rs_addr_EX(rs_addr_EX), .rt_addr_EX(rt_addr_EX), .wb_addr_EX(wb_addr_EX), .wb_addr_MEM(wb_addr_MEM),
    .wb_addr_WB(wb_addr_WB), .reg_write_EX(reg_write_EX), .reg_write_MEM(reg_write_MEM), .reg_write_WB(reg_write_WB),
    .mem_to_reg_EX(mem_to_reg_EX), .mem_to_reg_MEM(mem_to_reg_MEM), .branch_ID(branch_ID), .jump_reg(jump_reg),
    .jump_addr(jump_addr), .branch_taken(branch_taken), .mem_busy(mem_busy), .stall_pc(stall_pc),
    .stall_if_id(stall_if_id), .bubble_ex(bubble_ex), .freeze(freeze), .flush_if_id(flush_if_id), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .err_timeout(err_timeout));
  always #5 i_CLK = ~i_CLK;
  task automatic tick();
    @(posedge i_CLK);
    #1;
  endtask
  task automatic clear_inputs();
    {rs_addr_ID, rt_addr_ID, rs_addr_EX, rt_addr_EX, wb_addr_EX, wb_addr_MEM, wb_addr_WB} = '0;
    {rt_used_ID, reg_write_EX, reg_write_MEM, reg_write_WB, mem_to_reg_EX, mem_to_reg_MEM} = '0;
    {branch_ID, jump_reg, jump_addr, branch_taken, mem_busy} = '0;
    #1;
  endtask
  task automatic test_reset();
    i_RST = 1;
    clear_inputs();
    tick();
    mem_to_reg_EX = 1; reg_write_EX = 1; wb_addr_EX = 8; rs_addr_ID = 8; jump_addr = 1; mem_busy = 1;
    reg_write_MEM = 1; wb_addr_MEM = 5; rs_addr_EX = 5;
    #1;
    checks++;
    if ({stall_pc, stall_if_id, bubble_ex, freeze, flush_if_id, fwd_a, fwd_b} !== 9'b0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=0", {stall_pc, stall_if_id, bubble_ex, freeze, flush_if_id, fwd_a, fwd_b});
    end
    tick();
    i_RST = 0;
    clear_inputs();
    checks++;
    if ({stall_cnt, flush_cnt, err_timeout} !== 5'b0) begin
      errors++; $display("FAIL reset_state got=%b exp=0", {stall_cnt, flush_cnt, err_timeout});
    end
  endtask
  task automatic test_load_use();
    clear_inputs();
    mem_to_reg_EX = 1; reg_write_EX = 1; wb_addr_EX = 8; rs_addr_ID = 8;
    #1;
    checks++;
    if ({stall_pc, stall_if_id, bubble_ex, freeze, flush_if_id} !== 5'b11100) begin
      errors++; $display("FAIL lu_ctrl got=%b exp=11100", {stall_pc, stall_if_id, bubble_ex, freeze, flush_if_id});
    end
    tick();
    checks++;
    if (stall_cnt !== 2'd1) begin errors++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
    rs_addr_ID = 9; rt_addr_ID = 8; rt_used_ID = 0;
    #1;
    checks++;
    if (bubble_ex !== 1'b0) begin errors++; $display("FAIL lu_rt_unused got=%b exp=0", bubble_ex); end
    tick();
    rt_used_ID = 1;
    #1;
    checks++;
    if (bubble_ex !== 1'b1) begin errors++; $display("FAIL lu_rt_used got=%b exp=1", bubble_ex); end
    tick();
    checks++;
    if (stall_cnt !== 2'd2) begin errors++; $display("FAIL lu_cnt2 got=%0d exp=2", stall_cnt); end
    wb_addr_EX = 0; rs_addr_ID = 0; rt_addr_ID = 0;
    #1;
    checks++;
    if (stall_pc !== 1'b0) begin errors++; $display("FAIL lu_r0 got=%b exp=0", stall_pc); end
    clear_inputs();
  endtask
  task automatic test_forwarding();
    clear_inputs();
    rs_addr_ID = 20; rt_addr_ID = 21;
    reg_write_MEM = 1; reg_write_WB = 1; wb_addr_MEM = 5; wb_addr_WB = 5; rs_addr_EX = 5;
    #1;
    checks++;
    if (fwd_a !== (FWD ? 2'b01 : 2'b00) || bubble_ex !== 1'b0) begin
      errors++; $display("FAIL fwd_mem got=%b/%b exp=%b/0", fwd_a, bubble_ex, FWD ? 2'b01 : 2'b00);
    end
    mem_busy = 1;
    #1;
    checks++;
    if (fwd_a !== (FWD ? 2'b01 : 2'b00) || freeze !== 1'b1) begin
      errors++; $display("FAIL fwd_freeze got=%b/%b exp=%b/1", fwd_a, freeze, FWD ? 2'b01 : 2'b00);
    end
    mem_busy = 0; mem_to_reg_MEM = 1;
    #1;
    checks++;
    if (fwd_a !== (FWD ? 2'b10 : 2'b00)) begin errors++; $display("FAIL fwd_load_mem got=%b exp=%b", fwd_a, FWD ? 2'b10 : 2'b00); end
    mem_to_reg_MEM = 0; reg_write_MEM = 0;
    #1;
    checks++;
    if (fwd_a !== (FWD ? 2'b10 : 2'b00)) begin errors++; $display("FAIL fwd_wb got=%b exp=%b", fwd_a, FWD ? 2'b10 : 2'b00); end
    reg_write_MEM = 1; wb_addr_MEM = 6; rt_addr_EX = 6;
    #1;
    checks++;
    if (fwd_b !== (FWD ? 2'b01 : 2'b00)) begin errors++; $display("FAIL fwd_b_mem got=%b exp=%b", fwd_b, FWD ? 2'b01 : 2'b00); end
    wb_addr_MEM = 0; wb_addr_WB = 0; rt_addr_EX = 0; rs_addr_EX = 0;
    #1;
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0) begin errors++; $display("FAIL fwd_r0 got=%b exp=0000", {fwd_a, fwd_b}); end
    wb_addr_WB = 5; rs_addr_ID = 5;
    #1;
    checks++;
    if (bubble_ex !== !FWD) begin errors++; $display("FAIL wb_dep_hz got=%b exp=%b", bubble_ex, !FWD); end
    clear_inputs();
  endtask
  task automatic test_branch();
    clear_inputs();
    branch_ID = 1; branch_taken = 1; wb_addr_EX = 3; rs_addr_ID = 3; reg_write_EX = 1;
    #1;
    checks++;
    if ({flush_if_id, bubble_ex, stall_pc} !== 3'b011) begin
      errors++; $display("FAIL br_stall got=%b exp=011", {flush_if_id, bubble_ex, stall_pc});
    end
    tick();
    reg_write_EX = 0;
    #1;
    checks++;
    if ({flush_if_id, bubble_ex} !== 2'b10) begin errors++; $display("FAIL br_flush got=%b exp=10", {flush_if_id, bubble_ex}); end
    tick();
    checks++;
    if ({stall_cnt, flush_cnt} !== 4'b1101) begin
      errors++; $display("FAIL br_cnts got=%0d/%0d exp=3/1", stall_cnt, flush_cnt);
    end
    reg_write_MEM = 1; wb_addr_MEM = 3; mem_to_reg_MEM = 1;
    #1;
    checks++;
    if (bubble_ex !== 1'b1) begin errors++; $display("FAIL br_load_mem got=%b exp=1", bubble_ex); end
    mem_to_reg_MEM = 0;
    #1;
    checks++;
    if ({flush_if_id, bubble_ex} !== (FWD ? 2'b10 : 2'b01)) begin
      errors++; $display("FAIL br_alu_mem got=%b exp=%b", {flush_if_id, bubble_ex}, FWD ? 2'b10 : 2'b01);
    end
    clear_inputs();
  endtask
  task automatic test_freeze();
    clear_inputs();
    mem_to_reg_EX = 1; reg_write_EX = 1; wb_addr_EX = 8; rs_addr_ID = 8; jump_addr = 1; mem_busy = 1;
    #1;
    checks++;
    if ({freeze, stall_pc, stall_if_id, bubble_ex, flush_if_id} !== 5'b11100) begin
      errors++; $display("FAIL frz_ctrl got=%b exp=11100", {freeze, stall_pc, stall_if_id, bubble_ex, flush_if_id});
    end
    tick();
    checks++;
    if ({stall_cnt, flush_cnt} !== 4'b1101) begin
      errors++; $display("FAIL frz_cnts got=%0d/%0d exp=3/1", stall_cnt, flush_cnt);
    end
    clear_inputs();
    tick();
  endtask
  task automatic test_watchdog();
    clear_inputs();
    for (int r = 0; r < 2; r++) begin
      mem_busy = 1;
      repeat (3) tick();
      mem_busy = 0;
      tick();
    end
    checks++;
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL wd_short got=%b exp=0", err_timeout); end
    mem_busy = 1;
    repeat (3) tick();
    checks++;
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL wd_3 got=%b exp=0", err_timeout); end
    tick();
    checks++;
    if (err_timeout !== 1'b1) begin errors++; $display("FAIL wd_4 got=%b exp=1", err_timeout); end
    mem_busy = 0;
    tick();
    checks++;
    if (err_timeout !== 1'b1 || freeze !== 1'b0) begin
      errors++; $display("FAIL wd_sticky got=%b/%b exp=1/0", err_timeout, freeze);
    end
  endtask
  task automatic test_saturation();
    clear_inputs();
    jump_addr = 1;
    repeat (5) tick();
    checks++;
    if (flush_cnt !== 2'd3) begin errors++; $display("FAIL flush_sat got=%0d exp=3", flush_cnt); end
    clear_inputs();
    mem_to_reg_EX = 1; reg_write_EX = 1; wb_addr_EX = 8; rs_addr_ID = 8;
    tick();
    checks++;
    if (stall_cnt !== 2'd3) begin errors++; $display("FAIL stall_sat got=%0d exp=3", stall_cnt); end
    clear_inputs();
  endtask
  task automatic test_reset_mid_freeze();
    clear_inputs();
    mem_busy = 1;
    repeat (2) tick();
    i_RST = 1; jump_addr = 1; reg_write_MEM = 1; wb_addr_MEM = 5; rs_addr_EX = 5;
    #1;
    checks++;
    if ({freeze, stall_pc, flush_if_id, fwd_a} !== 5'b0) begin
      errors++; $display("FAIL rst_mid_out got=%b exp=0", {freeze, stall_pc, flush_if_id, fwd_a});
    end
    tick();
    checks++;
    if ({stall_cnt, flush_cnt, err_timeout} !== 5'b0) begin
      errors++; $display("FAIL rst_mid_state got=%b exp=0", {stall_cnt, flush_cnt, err_timeout});
    end
    i_RST = 0;
    clear_inputs();
    mem_busy = 1;
    repeat (3) tick();
    checks++;
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL rst_wait_abort got=%b exp=0", err_timeout); end
    clear_inputs();
  endtask
  initial begin
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch();
    test_freeze();
    test_watchdog();
    test_saturation();
    test_reset_mid_freeze();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Second-generation hazard unit for the 5-stage hardware-scheduled MIPS pipeline (IF/ID/EX/MEM/WB). Detects load-use and branch-operand RAW hazards and generates stall, bubble and flush controls, plus EX-stage forwarding selects. Adds global freeze for multi-cycle data memory, a memory-wait watchdog and saturating stall/flush performance counters. Sits beside the ID stage; all control outputs feed the pipeline registers and the PC.

Parameters:
ADDR_LEN, 5, register address width
TIMEOUT, 64, max consecutive mem_busy cycles before err_timeout (>=2)
CNT_W, 16, width of performance counters

Ports:
i_CLK  in  1  clock, rising edge
i_RST  in  1  synchronous active-high reset
rs_addr_ID  in  ADDR_LEN  rs of instruction in ID
rt_addr_ID  in  ADDR_LEN  rt of instruction in ID
rt_used_ID  in  1  ID instruction reads rt (rs always read)
rs_addr_EX  in  ADDR_LEN  rs of instruction in EX
rt_addr_EX  in  ADDR_LEN  rt of instruction in EX
wb_addr_EX / wb_addr_MEM / wb_addr_WB  in  ADDR_LEN  destination regs per stage
reg_write_EX / reg_write_MEM / reg_write_WB  in  1  stage writes register file
mem_to_reg_EX / mem_to_reg_MEM  in  1  stage holds a load
branch_ID  in  1  ID holds branch/jr (compares operands in ID)
jump_reg, jump_addr, branch_taken  in  1  control transfer resolved in ID
mem_busy  in  1  data memory not ready this cycle
stall_pc  out  1  hold PC
stall_if_id  out  1  hold IF/ID
bubble_ex  out  1  load NOP into ID/EX
freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
flush_if_id  out  1  clear IF/ID
fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
stall_cnt  out  CNT_W  load-use/branch stall cycles
flush_cnt  out  CNT_W  flush cycles
err_timeout  out  1  sticky watchdog error

Behaviour:
- Address 0 never matches (writes to $0 ignored); match requires corresponding reg_write_X=1.
- rt compares gated by rt_used_ID.
- Combinational hazards (same cycle):
  - lu = mem_to_reg_EX & match(ID src, wb_addr_EX).
  - br = branch_ID & (match(ID src, wb_addr_EX) | (mem_to_reg_MEM & match(ID src, wb_addr_MEM))).
  - hz = lu | br.
- Priority: freeze > hz > flush.
  - mem_busy=1: freeze=1, stall_pc=1, stall_if_id=1, bubble_ex=0, flush_if_id=0.
  - Else hz: stall_pc=1, stall_if_id=1, bubble_ex=1, flush_if_id=0 (branch re-evaluated next cycle).
  - Else: flush_if_id = jump_reg|jump_addr|branch_taken.
- Forwarding, per operand: EX/MEM match (reg_write_MEM & !mem_to_reg_MEM) → 01; else MEM/WB match → 10; else 00. Forwarding selects stay valid during freeze.
- Watchdog, registered:
  - wait_cnt (clog2(TIMEOUT)+1 bits) increments each mem_busy cycle and clears on mem_busy=0.
  - When mem_busy=1 and wait_cnt==TIMEOUT-1, err_timeout sets on that edge and stays 1 until reset.
  - Freeze output is unaffected by err_timeout.
- Counters, registered, saturate at all-ones (no wrap):
  - stall_cnt +1 per cycle with hz & !mem_busy.
  - flush_cnt +1 per cycle flush_if_id=1.
- Reset (i_RST=1 at edge): wait_cnt, stall_cnt, flush_cnt, err_timeout ← 0. While i_RST=1, all combinational outputs forced to 0 (stall/flush/freeze/bubble/fwd). Reset mid-freeze aborts the wait, with no error.

Optional Feature:
HAZARD_FWD_EN
- Defined: behaviour as above.
- Undefined: no forwarding. fwd_a=fwd_b=00 always. Any ID source matching wb_addr_EX, wb_addr_MEM or wb_addr_WB of a writing stage raises hz (regfile write-before-read not assumed). Counters and watchdog unchanged.

Test Plan:
- Load-use stall: EX lw $8 (mem_to_reg_EX=1, wb_addr_EX=8), ID rs=8 → stall_pc=stall_if_id=bubble_ex=1 for 1 cycle; stall_cnt 0→1.
- Forwarding priority: wb_addr_MEM=wb_addr_WB=5, both writing, rs_addr_EX=5 → fwd_a=01; drop reg_write_MEM → fwd_a=10; rt_addr_EX=0 with wb_addr=0 → fwd_b=00.
- Branch vs hazard: branch_ID=1, branch_taken=1, wb_addr_EX=3=rs_addr_ID, reg_write_EX=1 → flush_if_id=0, bubble_ex=1; next cycle with hazard gone → flush_if_id=1, flush_cnt=1.
- Freeze priority: mem_busy=1 together with lu and jump_addr → freeze=1, bubble_ex=0, flush_if_id=0; stall_cnt unchanged.
- Watchdog: TIMEOUT=4, mem_busy held 4 cycles → err_timeout=1 after 4th edge and sticky after mem_busy=0. Held 3 cycles, drop 1, held 3 more → err_timeout stays 0.
- Saturation/reset: CNT_W=2, 5 flush cycles → flush_cnt=3. Assert i_RST for 1 cycle → all counters 0 and outputs 0 during reset.
